// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS pipeline: next-PC select encodings, reset vector
// and the canonical nop.
package cpu_defs;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = '0;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, absolute jump and
// register jump. Branch and jump targets are relative to the instruction held in D.
module npc_calc
    import cpu_defs::*;
(
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    input  logic [31:0] rs_val_d,
    output logic [31:0] npc
);

    logic [31:0] pc_f4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    always_comb begin
        pc_f4     = pc_f + 32'd4;
        br_target = pc_d + 32'd4 + br_offset(instr_d[15:0]);
        j_target  = {pc_d[31:28], instr_d[25:0], 2'b00};
        npc       = pc_f4;
        unique case (npc_sel_e'(npc_sel))
            NPC_SEQ: npc = pc_f4;
            NPC_BR:  npc = br_taken ? br_target : pc_f4;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = rs_val_d;
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC register, fetch-address check and
// registered instruction/PC handed to decode. Branches use one delay slot, no flush.
module if_id_stage
    import cpu_defs::NOP;
#(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int unsigned IM_WORDS = 4096
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] rs_val_d,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic [15:0] imm_d,
    output logic        valid_d,
    output logic        addr_err_d
);

    // 33-bit limit so a fetch window ending at 2^32 does not wrap to zero.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

    logic [31:0] npc;
    logic        err_f;
    logic [31:0] fetch_word;

    npc_calc u_npc_calc (
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .pc_f     (pc_f),
        .pc_d     (pc_d),
        .instr_d  (instr_d),
        .rs_val_d (rs_val_d),
        .npc      (npc)
    );

    always_comb begin
        err_f      = (pc_f[1:0] != 2'b00) | (pc_f < RESET_PC) | ({1'b0, pc_f} >= PC_LIMIT);
        fetch_word = err_f ? NOP : instr_f;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f       <= RESET_PC;
            instr_d    <= NOP;
            pc_d       <= RESET_PC;
            valid_d    <= 1'b0;
            addr_err_d <= 1'b0;
        end else if (!stall) begin
            pc_f       <= npc;
            instr_d    <= fetch_word;
            pc_d       <= pc_f;
            valid_d    <= 1'b1;
            addr_err_d <= err_f;
        end
    end

    assign pc8_d = pc_d + 32'd8;
    assign imm_d = instr_d[15:0];

endmodule
